banked_memory: RTL and testbench
================================

# banked_memory

Parametrised, bank-interleaved single-port RAM. It succeeds the fixed 8-bit / 8-byte / 32-byte memory chain with generic data width, depth and bank count. It adds a valid/ready request interface, a registered read response and a hardware clear sequencer that zeroes every word after reset or on demand. It sits between the datapath bus logic and storage, and drives a plain output bus with no tristate.

## Interface
- DATA_W, 8, word width in bits
- ADDR_W, 5, address width; DEPTH = 2^ADDR_W words
- BANKS, 4, bank count; power of 2, 1 ≤ BANKS ≤ DEPTH; ROWS = DEPTH/BANKS
- clk  input  1  clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low
- req_valid  input  1  request present
- req_ready  output  1  block accepts a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  word address
- req_wdata  input  DATA_W  write data
- clear_req  input  1  start a full-memory clear (sampled in READY only)
- rsp_valid  output  1  read data valid
- rsp_rdata  output  DATA_W  read data; 0 when rsp_valid = 0
- busy  output  1  clear sequence in progress

## Operation
- Address map: bank = req_addr[log2(BANKS)-1:0] (low bits interleave), row = req_addr[ADDR_W-1:log2(BANKS)]. For BANKS = 1 the full address is the row.
- Two-state FSM:
  - CLEAR: row counter r walks 0..ROWS-1. Each edge writes 0 to row r of every bank in parallel. After row ROWS-1 is written, the FSM goes to READY.
  - READY: req_ready = 1. A request is accepted on an edge with req_valid && req_ready.
    - Write: the addressed word takes req_wdata. No response.
    - Read: the addressed word is registered into rsp_rdata and rsp_valid = 1 for one cycle.
  - clear_req = 1 in READY: the FSM enters CLEAR on the same edge and r resets to 0.
- busy = (state == CLEAR). req_ready = (state == READY). Both are derived from state only.
- A request is accepted in the same cycle as clear_req: it completes. A write lands and is then overwritten by the clear. A read returns the pre-clear data.
- req_valid while req_ready = 0 is ignored: no write, no response, no error.
- clear_req in CLEAR is ignored. The sequence does not restart.
- Storage is not reset asynchronously. Only the sequencer zeroes it.
- Reset assertion at any time, including mid-clear or with a read in flight:
  - state = CLEAR, r = 0, rsp_valid = 0, rsp_rdata = 0
  - any pending response is dropped
  - on release the full clear runs from row 0

## Timing
- Reset values: req_ready = 0, busy = 1, rsp_valid = 0, rsp_rdata = 0.
- After reset release, edges 1..ROWS clear rows 0..ROWS-1. busy falls and req_ready rises after edge ROWS. With defaults that is 8 cycles.
- clear_req clear duration: busy high for exactly ROWS cycles.
- Read latency is 1: a request accepted at edge n gives rsp_valid = 1 in the cycle after edge n, dropping at edge n+1 unless another read is accepted.
- Back-to-back throughput is one request per cycle, reads and writes in any mix.
- Read-after-write to the same address on the next cycle returns the new data (write at edge n, read at edge n+1).
- A read accepted on the edge that enters CLEAR still delivers its response in the following cycle.

## Test plan
- Reset release with defaults -> busy = 1 for 8 cycles, then req_ready = 1. Read all 32 addresses -> rsp_rdata = 0x00 each, rsp_valid one cycle after each accept.
- Write 0xA5 to addr 5 and 0x3C to addr 6 back-to-back, then read 5 and 6 back-to-back -> 0xA5 then 0x3C on consecutive cycles, rsp_valid high for 2 cycles.
- Write 0x77 to addr 31 (bank 3, row 7), read 31 on the next cycle -> 0x77. Read 30 -> 0x00.
- Fill addrs 0..31 with addr^0xFF, pulse clear_req together with a read of addr 2 -> rsp 0xFD. Then busy = 1 for 8 cycles and req_valid is ignored. Afterwards all reads return 0x00.
- Assert reset during CLEAR at r = 3, with a read response pending in a second run -> outputs go to reset values immediately. After release: 8-cycle clear, then all reads return 0.
- DATA_W = 16, ADDR_W = 6, BANKS = 8 -> clear lasts 8 cycles. Write 0xBEEF to addr 63 and 0x1234 to addr 0, read both back -> exact values, all others 0x0000.

Source files
------------

// File: rtl/banked_memory_if.sv
// Request/response bus for banked_memory: valid/ready requests, registered read
// response, and the clear sequencer's control/status.
interface banked_memory_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              clear_req;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, clear_req,
      input  req_ready, rsp_valid, rsp_rdata, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, clear_req,
      output req_ready, rsp_valid, rsp_rdata, busy
   );
endinterface

// File: rtl/banked_memory.sv
// Bank-interleaved single-port RAM with a registered read response and a
// row-parallel clear sequencer that zeroes all storage after reset or on request.
module banked_memory #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 5,
   parameter int BANKS  = 4
) (
   input  logic           clk,
   input  logic           reset,
   banked_memory_if.slave bus
);
   localparam int DEPTH  = 1 << ADDR_W;
   localparam int LOG2B  = $clog2(BANKS);
   localparam int ROWS   = DEPTH / BANKS;
   localparam int ROW_W  = (ADDR_W - LOG2B) > 0 ? (ADDR_W - LOG2B) : 1;
   localparam int BSEL_W = LOG2B > 0 ? LOG2B : 1;

   typedef enum logic {CLEAR, READY} state_t;

   state_t             state_reg, state_next;
   logic [ROW_W-1:0]   clr_row_reg;
   logic               clr_last;
   logic               rsp_valid_reg;
   logic [BSEL_W-1:0]  rsp_bank_reg;
   logic               rd_accept, wr_accept;
   logic [ROW_W-1:0]   req_row;
   logic [BSEL_W-1:0]  req_bank;
   logic [DATA_W-1:0]  bank_rdata [BANKS];

   // Low address bits pick the bank, the rest pick the row.
   assign req_row = ROW_W'(bus.req_addr >> LOG2B);
   generate
      if (LOG2B > 0) begin : g_bsel
         assign req_bank = bus.req_addr[BSEL_W-1:0];
      end else begin : g_bsel_single
         assign req_bank = 1'b0;
      end
   endgenerate

   assign rd_accept = bus.req_valid && (state_reg == READY) && !bus.req_write;
   assign wr_accept = bus.req_valid && (state_reg == READY) &&  bus.req_write;
   assign clr_last  = (clr_row_reg == ROW_W'(ROWS - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= CLEAR;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         CLEAR:   if (clr_last)      state_next = READY;
         READY:   if (bus.clear_req) state_next = CLEAR;
         default: state_next = CLEAR;
      endcase
   end

   always_comb begin
      bus.req_ready = (state_reg == READY);
      bus.busy      = (state_reg == CLEAR);
   end

   // Row counter idles at 0 in READY so every clear starts from row 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clr_row_reg <= '0;
      end else if (state_reg == CLEAR && !clr_last) begin
         clr_row_reg <= clr_row_reg + 1'b1;
      end else begin
         clr_row_reg <= '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rsp_valid_reg <= 1'b0;
         rsp_bank_reg  <= '0;
      end else begin
         rsp_valid_reg <= rd_accept;
         if (rd_accept) begin
            rsp_bank_reg <= req_bank;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < BANKS; gi++) begin : g_bank
         logic [DATA_W-1:0] mem [ROWS];
         logic [DATA_W-1:0] rdata_reg;
         logic              we;
         logic [ROW_W-1:0]  waddr;
         logic [DATA_W-1:0] wdata;

         always_comb begin
            we    = 1'b0;
            waddr = req_row;
            wdata = bus.req_wdata;
            if (state_reg == CLEAR) begin
               we    = 1'b1;
               waddr = clr_row_reg;
               wdata = '0;
            end else if (wr_accept && req_bank == BSEL_W'(gi)) begin
               we = 1'b1;
            end
         end

         // Storage has no reset; only the clear sequencer zeroes it.
         always_ff @(posedge clk) begin
            if (we) begin
               mem[waddr] <= wdata;
            end
            if (rd_accept && req_bank == BSEL_W'(gi)) begin
               rdata_reg <= mem[req_row];
            end
         end

         assign bank_rdata[gi] = rdata_reg;
      end
   endgenerate

   assign bus.rsp_valid = rsp_valid_reg;
   assign bus.rsp_rdata = rsp_valid_reg ? bank_rdata[rsp_bank_reg] : '0;
endmodule

// File: tb/tb_banked_memory.sv
// Randomised and directed checks of banked_memory against an array-based
// reference model, plus a second wide/8-bank instance checked with literals.
module tb_banked_memory;
   localparam int ROWS1 = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   banked_memory_if #(.DATA_W(8), .ADDR_W(5)) bus ();
   banked_memory #(.DATA_W(8), .ADDR_W(5), .BANKS(4)) dut (
      .clk(clk), .reset(rst_n), .bus(bus)
   );

   banked_memory_if #(.DATA_W(16), .ADDR_W(6)) bus2 ();
   banked_memory #(.DATA_W(16), .ADDR_W(6), .BANKS(8)) dut2 (
      .clk(clk), .reset(rst_n), .bus(bus2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: flat word array, a count of busy cycles left, and the
   // response expected in the cycle after each edge.
   logic [7:0] m_mem [32];
   int         m_clear_left = ROWS1;
   logic       m_rsp_v = 1'b0;
   logic [7:0] m_rsp_d = 8'h00;

   initial foreach (m_mem[i]) m_mem[i] = 8'h00;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_clear_left = ROWS1;
         m_rsp_v = 1'b0;
         m_rsp_d = 8'h00;
         foreach (m_mem[i]) m_mem[i] = 8'h00;
      end else begin
         m_rsp_v = 1'b0;
         m_rsp_d = 8'h00;
         if (m_clear_left == 0) begin
            if (bus.req_valid) begin
               if (bus.req_write) begin
                  m_mem[bus.req_addr] = bus.req_wdata;
               end else begin
                  m_rsp_v = 1'b1;
                  m_rsp_d = m_mem[bus.req_addr];
               end
            end
            if (bus.clear_req) begin
               foreach (m_mem[i]) m_mem[i] = 8'h00;
               m_clear_left = ROWS1;
            end
         end else begin
            m_clear_left--;
         end
      end
   end

   always @(negedge clk) begin
      chk("busy",      {31'd0, bus.busy},      {31'd0, m_clear_left != 0});
      chk("req_ready", {31'd0, bus.req_ready}, {31'd0, m_clear_left == 0});
      chk("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, m_rsp_v});
      chk("rsp_rdata", {24'd0, bus.rsp_rdata}, {24'd0, m_rsp_d});
   end

   task automatic step(input logic v, input logic w, input logic [4:0] a,
                       input logic [7:0] d, input logic c);
      @(posedge clk);
      #1;
      bus.req_valid = v;
      bus.req_write = w;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.clear_req = c;
   endtask

   task automatic step2(input logic v, input logic w, input logic [5:0] a,
                        input logic [15:0] d);
      @(posedge clk);
      #1;
      bus2.req_valid = v;
      bus2.req_write = w;
      bus2.req_addr  = a;
      bus2.req_wdata = d;
      bus2.clear_req = 1'b0;
   endtask

   task automatic wait_ready(input string name, output int n);
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!bus.req_ready) chk({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic read_all();
      for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 5'(i), 8'h00, 1'b0);
      step(1'b0, 1'b0, 5'd0, 8'h00, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [15:0] e2;
      bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0;
      bus.req_wdata = 0; bus.clear_req = 0;
      bus2.req_valid = 0; bus2.req_write = 0; bus2.req_addr = 0;
      bus2.req_wdata = 0; bus2.clear_req = 0;

      repeat (3) @(negedge clk);
      chk("rst_busy",  {31'd0, bus.busy},      32'd1);
      chk("rst_ready", {31'd0, bus.req_ready}, 32'd0);
      chk("rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_rdata", {24'd0, bus.rsp_rdata}, 32'd0);

      @(posedge clk); #1 rst_n = 1'b1;
      wait_ready("init_clear", n);
      chk("init_clear_cycles", n, 32'd8);
      read_all();

      step(1, 1, 5'd5, 8'hA5, 0);
      step(1, 1, 5'd6, 8'h3C, 0);
      step(1, 0, 5'd5, 8'h00, 0);
      step(1, 0, 5'd6, 8'h00, 0);
      @(negedge clk);
      chk("rd5_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rd5_data",  {24'd0, bus.rsp_rdata}, 32'hA5);
      step(0, 0, 5'd0, 8'h00, 0);
      @(negedge clk);
      chk("rd6_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rd6_data",  {24'd0, bus.rsp_rdata}, 32'h3C);
      step(0, 0, 5'd0, 8'h00, 0);
      @(negedge clk);
      chk("rsp_drop", {31'd0, bus.rsp_valid}, 32'd0);

      step(1, 1, 5'd31, 8'h77, 0);
      step(1, 0, 5'd31, 8'h00, 0);
      step(1, 0, 5'd30, 8'h00, 0);
      @(negedge clk);
      chk("raw31_data", {24'd0, bus.rsp_rdata}, 32'h77);
      step(0, 0, 5'd0, 8'h00, 0);
      @(negedge clk);
      chk("rd30_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("rd30_data",  {24'd0, bus.rsp_rdata}, 32'h00);

      // Fill, then clear with a concurrent read; requests during clear must be ignored.
      for (int i = 0; i < 32; i++) step(1, 1, 5'(i), 8'(i) ^ 8'hFF, 0);
      step(1, 0, 5'd2, 8'h00, 1);
      step(1, 1, 5'd4, 8'hEE, 0);
      @(negedge clk);
      chk("clr_read_data", {24'd0, bus.rsp_rdata}, 32'hFD);
      wait_ready("req_clear", n);
      bus.req_valid = 1'b0;
      chk("req_clear_cycles", n, 32'd8);
      read_all();

      // Randomised mix including occasional clears.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              8'($urandom), $urandom_range(0, 49) == 0);
      end
      step(0, 0, 5'd0, 8'h00, 0);
      wait_ready("rand_settle", n);
      read_all();

      // Reset in the middle of a clear, at row 3.
      step(0, 0, 5'd0, 8'h00, 1);
      step(0, 0, 5'd0, 8'h00, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midclr_rst_busy",  {31'd0, bus.busy},      32'd1);
      chk("midclr_rst_ready", {31'd0, bus.req_ready}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_ready("midclr_release", n);
      chk("midclr_release_cycles", n, 32'd8);
      read_all();

      // Reset with a read response in flight.
      step(1, 1, 5'd9, 8'h5A, 0);
      step(1, 0, 5'd9, 8'h00, 0);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
      chk("inflight_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("inflight_data",  {24'd0, bus.rsp_rdata}, 32'h5A);
      #1 rst_n = 1'b0;
      #1;
      chk("inflight_rst_valid", {31'd0, bus.rsp_valid}, 32'd0);
      chk("inflight_rst_data",  {24'd0, bus.rsp_rdata}, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      n = 0;
      while (!bus2.req_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("wide_clear_cycles", n, 32'd8);
      read_all();

      // Wide 8-bank instance.
      step2(1, 1, 6'd63, 16'hBEEF);
      step2(1, 1, 6'd0,  16'h1234);
      for (int i = 0; i <= 64; i++) begin
         step2(i < 64, 0, 6'(i), 16'h0000);
         if (i > 0) begin
            @(negedge clk);
            e2 = (i - 1 == 63) ? 16'hBEEF : (i - 1 == 0) ? 16'h1234 : 16'h0000;
            chk($sformatf("wide_rd%0d", i - 1), {16'd0, bus2.rsp_rdata}, {16'd0, e2});
            chk($sformatf("wide_v%0d", i - 1), {31'd0, bus2.rsp_valid}, 32'd1);
         end
      end

      step(0, 0, 5'd0, 8'h00, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
